conv_pass_sequencer: RTL and testbench
======================================

# conv_pass_sequencer

Sequences the P-lane convolution datapath: x-buffer lane memories, shared filter ROM, P MAC units and output write port. Each frame it runs ceil(NOUT/P) passes, NOUT = LENX-LENF+1. A pass clears the accumulators, streams LENF coefficient/sample address pairs, then hands the P results to the output buffer. It sits between the x-buffer load controller (x_full/x_release) and the output drain controller (wr_valid/wr_ready, out_drained).

## Interface

Parameters:
- LENX, 64, samples per frame.
- LENF, 33, filter taps.
- P, 4, parallel MAC lanes.
- ADDRX, 6, x/output address width.
- ADDRF, 6, filter ROM address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; forces reset values immediately.
- x_full  in  1  level; x buffer holds a complete frame.
- x_release  out  1  1-cycle pulse; frame consumed, loader may refill.
- x_addr  out  P*ADDRX  lane i read address at bits [i*ADDRX +: ADDRX].
- f_addr  out  ADDRF  filter ROM address.
- clr_acc  out  1  clear all MAC accumulators this cycle.
- en_acc  out  1  accumulate the ROM/memory data returned this cycle.
- wr_valid  out  1  pass results ready for the output buffer.
- wr_ready  in  1  output buffer accepts the pass.
- wr_base  out  ADDRX  output index of lane 0.
- wr_count  out  $clog2(P)+1  number of valid lanes, 1..P.
- lane_mask  out  P  bit i = lane i holds a valid output.
- busy  out  1  state is not IDLE.
- conv_done  out  1  level; all passes written, waiting for drain.
- out_drained  in  1  pulse; output buffer fully sent.

## Operation

- States: IDLE, CLEAR, MAC, DRAIN, WRITE, DONE. Registers: state, base (next output index), k (tap counter), en_acc pipeline bit.
- IDLE: x_full=1 -> CLEAR, base=0.
- CLEAR, one cycle: clr_acc=1, k=0 -> MAC.
- MAC, LENF cycles. f_addr=k. x_addr lane i = min(base+i+k, LENX-1); the clamp only affects masked lanes. After k=LENF-1 -> DRAIN, else k+1.
- en_acc is a registered copy of the MAC state, so it is high the cycle after each address issue. This matches the 1-cycle read latency of the memories and ROM.
- DRAIN, one cycle: en_acc=1 for the last tap, no new address -> WRITE.
- WRITE: wr_valid=1. wr_base=base. wr_count=min(P, NOUT-base). lane_mask has the low wr_count bits set. These are stable until handshake.
- On wr_valid&wr_ready: base+=P. If the new base >= NOUT -> DONE, else -> CLEAR.
- DONE: conv_done=1. out_drained=1 -> IDLE, with x_release pulsed in the first IDLE cycle.
- x_full is ignored outside IDLE. out_drained is ignored outside DONE.
- Address arithmetic is done at ADDRX+1 bits, then clamped. base never exceeds NOUT+P-1.

## Timing

- Reset values: state IDLE; x_addr all lanes 0; f_addr 0; clr_acc 0; en_acc 0; wr_valid 0; wr_base 0; wr_count 0; lane_mask 0; busy 0; conv_done 0; x_release 0.
- Reset mid-pass abandons the frame with no wr_valid and no x_release.
- Cycle numbering: x_full sampled high at edge E0.
  - clr_acc high in cycle 1.
  - f_addr=0 in cycle 2; f_addr=LENF-1 in cycle LENF+1.
  - en_acc high in cycles 3..LENF+2.
  - wr_valid first high in cycle LENF+3.
- Pass length with wr_ready held high is LENF+3 cycles (36 at defaults). Each cycle of wr_ready low adds one cycle.
- Default frame: 8 passes, 288 cycles. conv_done rises in cycle 289.
- All outputs are registered. Outputs are a function of state only, never of same-cycle inputs.

## Test plan

- Defaults, wr_ready=1, x_full at E0:
  - wr_valid in cycles 36, 72, ..., 288, with wr_base 0,4,...,28, wr_count=4, lane_mask=4'b1111.
  - conv_done at 289.
- Address trace, pass 1 (base=4):
  - lane 3 x_addr steps 7..39 while f_addr steps 0..32.
  - en_acc is high exactly 33 cycles per pass, and clr_acc exactly 1 cycle.
- P=3 override:
  - 11 passes; last pass wr_base=30, wr_count=2, lane_mask=3'b011.
  - lane 2 x_addr clamps to 63 at k=32.
- Backpressure: hold wr_ready=0 for 5 cycles in pass 0.
  - wr_valid/wr_base/lane_mask stay stable.
  - pass 1 clr_acc comes 1 cycle after the handshake.
  - frame ends 5 cycles later than the default run.
- Drain handshake:
  - out_drained pulsed during MAC -> ignored.
  - In DONE -> IDLE, x_release pulse 1 cycle, busy=0.
  - With x_full still high, the next frame's clr_acc follows 2 cycles after x_release.
- Reset asserted mid-MAC (cycle 20), checked immediately, before the next edge:
  - all outputs take reset values without waiting for a clock edge; no wr_valid.
  - After deassert with x_full=1, a full frame runs normally.

Source files
------------

// File: rtl/conv_pass_sequencer.sv
// conv_pass_sequencer
// Sequences a P-lane convolution datapath. Each frame is split into
// ceil(NOUT/P) passes. A pass clears the accumulators, issues LENF
// filter/sample address pairs, then offers the P results to the output buffer.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   x_full            x buffer holds a full frame (level, sampled in IDLE only)
//   x_release         1-cycle pulse, frame consumed, loader may refill
//   x_addr            per-lane x read address, lane i at [i*ADDRX +: ADDRX]
//   f_addr            filter ROM address
//   clr_acc, en_acc   MAC accumulator clear / accumulate strobes
//   wr_valid/ready    pass result handshake with the output buffer
//   wr_base           output index of lane 0
//   wr_count          number of valid lanes (1..P)
//   lane_mask         per-lane valid bits
//   busy, conv_done   not idle / all passes written, waiting for drain
//   out_drained       output buffer fully sent (pulse, sampled in DONE only)
module conv_pass_sequencer #(
    parameter int unsigned LENX  = 64,
    parameter int unsigned LENF  = 33,
    parameter int unsigned P     = 4,
    parameter int unsigned ADDRX = 6,
    parameter int unsigned ADDRF = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x_full,
    output logic               x_release,
    output logic [P*ADDRX-1:0] x_addr,
    output logic [ADDRF-1:0]   f_addr,
    output logic               clr_acc,
    output logic               en_acc,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [ADDRX-1:0]   wr_base,
    output logic [$clog2(P):0] wr_count,
    output logic [P-1:0]       lane_mask,
    output logic               busy,
    output logic               conv_done,
    input  logic               out_drained
);

    localparam int unsigned NOUT = LENX - LENF + 1;
    // One extra bit so base+lane+tap can exceed LENX-1 before clamping.
    localparam int unsigned AW   = ADDRX + 1;
    localparam int unsigned KW   = (LENF > 1) ? $clog2(LENF) : 1;
    localparam int unsigned CW   = $clog2(P) + 1;

    localparam logic [AW-1:0] NoutW = AW'(NOUT);
    localparam logic [AW-1:0] XMaxW = AW'(LENX - 1);
    localparam logic [AW-1:0] PW    = AW'(P);
    localparam logic [KW-1:0] KLast = KW'(LENF - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StMac,
        StDrain,
        StWrite,
        StDone
    } state_e;

    state_e        state_q;
    logic [AW-1:0] base_q;
    logic [KW-1:0] k_q;

    logic [KW-1:0]      k_issue;
    logic [AW-1:0]      lane_sum [P];
    logic [P*ADDRX-1:0] x_addr_d;
    logic [AW-1:0]      remaining;
    logic [CW-1:0]      count_d;
    logic [P-1:0]       mask_d;
    logic [AW-1:0]      base_next;
    logic               pass_last;

    // Tap whose addresses get registered at the coming edge: tap 0 when
    // leaving CLEAR, otherwise the tap after the current one.
    assign k_issue = (state_q == StMac) ? k_q + KW'(1) : '0;

    always_comb begin
        lane_sum = '{default: '0};
        x_addr_d = '0;
        for (int i = 0; i < P; i++) begin
            lane_sum[i] = base_q + AW'(i) + AW'(k_issue);
            // Only masked lanes of the last pass ever hit the clamp.
            x_addr_d[i*ADDRX +: ADDRX] = (lane_sum[i] > XMaxW) ? XMaxW[ADDRX-1:0]
                                                               : lane_sum[i][ADDRX-1:0];
        end
    end

    assign remaining = NoutW - base_q;
    assign count_d   = (remaining >= PW) ? CW'(P) : CW'(remaining);
    assign base_next = base_q + PW;
    assign pass_last = (base_next >= NoutW);

    always_comb begin
        mask_d = '0;
        for (int i = 0; i < P; i++) begin
            mask_d[i] = (AW'(i) < remaining);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            base_q    <= '0;
            k_q       <= '0;
            x_addr    <= '0;
            f_addr    <= '0;
            clr_acc   <= 1'b0;
            en_acc    <= 1'b0;
            wr_valid  <= 1'b0;
            wr_base   <= '0;
            wr_count  <= '0;
            lane_mask <= '0;
            busy      <= 1'b0;
            conv_done <= 1'b0;
            x_release <= 1'b0;
        end else begin
            // Memories and ROM return data one cycle after the address.
            en_acc    <= (state_q == StMac);
            clr_acc   <= 1'b0;
            x_release <= 1'b0;

            case (state_q)
                StIdle: begin
                    // x_full is still the stale level of the frame just released;
                    // wait one cycle for the loader to see x_release.
                    if (x_full && !x_release) begin
                        state_q <= StClear;
                        base_q  <= '0;
                        clr_acc <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                StClear: begin
                    state_q <= StMac;
                    k_q     <= '0;
                    f_addr  <= ADDRF'(k_issue);
                    x_addr  <= x_addr_d;
                end
                StMac: begin
                    if (k_q == KLast) begin
                        state_q <= StDrain;
                    end else begin
                        k_q    <= k_issue;
                        f_addr <= ADDRF'(k_issue);
                        x_addr <= x_addr_d;
                    end
                end
                StDrain: begin
                    state_q   <= StWrite;
                    wr_valid  <= 1'b1;
                    wr_base   <= base_q[ADDRX-1:0];
                    wr_count  <= count_d;
                    lane_mask <= mask_d;
                end
                StWrite: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        base_q   <= base_next;
                        if (pass_last) begin
                            state_q   <= StDone;
                            conv_done <= 1'b1;
                        end else begin
                            state_q <= StClear;
                            clr_acc <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (out_drained) begin
                        state_q   <= StIdle;
                        conv_done <= 1'b0;
                        busy      <= 1'b0;
                        x_release <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pass_sequencer.sv
// Bench for conv_pass_sequencer: a P=4 (default) and a P=3 instance, each
// frame walked pass by pass against the timing rules of the sequencer.
module tb_conv_pass_sequencer;

    localparam int LENX  = 64;
    localparam int LENF  = 33;
    localparam int ADDRX = 6;
    localparam int ADDRF = 6;
    localparam int PA    = 4;
    localparam int PB    = 3;
    localparam int NOUT  = LENX - LENF + 1;

    logic clk;
    logic reset;
    logic sel;
    logic x_full, wr_ready, out_drained;

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus goes only to the instance under test; the other sees idle inputs.
    logic xf_a, wr_a, od_a, xf_b, wr_b, od_b;
    assign xf_a = !sel && x_full;
    assign wr_a = !sel && wr_ready;
    assign od_a = !sel && out_drained;
    assign xf_b = sel && x_full;
    assign wr_b = sel && wr_ready;
    assign od_b = sel && out_drained;

    logic              xr_a, clr_a, en_a, wv_a, busy_a, done_a;
    logic [PA*ADDRX-1:0] xa_a;
    logic [ADDRF-1:0]  fa_a;
    logic [ADDRX-1:0]  wb_a;
    logic [2:0]        wc_a;
    logic [PA-1:0]     lm_a;

    logic              xr_b, clr_b, en_b, wv_b, busy_b, done_b;
    logic [PB*ADDRX-1:0] xa_b;
    logic [ADDRF-1:0]  fa_b;
    logic [ADDRX-1:0]  wb_b;
    logic [2:0]        wc_b;
    logic [PB-1:0]     lm_b;

    conv_pass_sequencer #(
        .LENX(LENX), .LENF(LENF), .P(PA), .ADDRX(ADDRX), .ADDRF(ADDRF)
    ) dut_a (
        .clk(clk), .reset(reset), .x_full(xf_a), .x_release(xr_a), .x_addr(xa_a),
        .f_addr(fa_a), .clr_acc(clr_a), .en_acc(en_a), .wr_valid(wv_a), .wr_ready(wr_a),
        .wr_base(wb_a), .wr_count(wc_a), .lane_mask(lm_a), .busy(busy_a),
        .conv_done(done_a), .out_drained(od_a)
    );

    conv_pass_sequencer #(
        .LENX(LENX), .LENF(LENF), .P(PB), .ADDRX(ADDRX), .ADDRF(ADDRF)
    ) dut_b (
        .clk(clk), .reset(reset), .x_full(xf_b), .x_release(xr_b), .x_addr(xa_b),
        .f_addr(fa_b), .clr_acc(clr_b), .en_acc(en_b), .wr_valid(wv_b), .wr_ready(wr_b),
        .wr_base(wb_b), .wr_count(wc_b), .lane_mask(lm_b), .busy(busy_b),
        .conv_done(done_b), .out_drained(od_b)
    );

    // Outputs of the instance under test, widened to the P=4 shape.
    logic                o_xr, o_clr, o_en, o_wv, o_busy, o_done;
    logic [PA*ADDRX-1:0] o_xa;
    logic [ADDRF-1:0]    o_fa;
    logic [ADDRX-1:0]    o_wb;
    logic [2:0]          o_wc;
    logic [PA-1:0]       o_lm;
    assign o_xr   = sel ? xr_b : xr_a;
    assign o_clr  = sel ? clr_b : clr_a;
    assign o_en   = sel ? en_b : en_a;
    assign o_wv   = sel ? wv_b : wv_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_xa   = sel ? {{ADDRX{1'b0}}, xa_b} : xa_a;
    assign o_fa   = sel ? fa_b : fa_a;
    assign o_wb   = sel ? wb_b : wb_a;
    assign o_wc   = sel ? wc_b : wc_a;
    assign o_lm   = sel ? {1'b0, lm_b} : lm_a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks one frame from x_full in IDLE to the cycle after x_release.
    // Precondition: called 1 time unit after an edge with the DUT idle and
    // ready to start at the next edge. mode: 0 wr_ready held high,
    // 1 wr_ready low for 5 write cycles of pass 0, 2 random stalls and noise.
    task automatic run_frame(input bit use_b, input int mode, input bit drain_in_mac,
                             input bit keep_full);
        int  np, npass, base, exp_a, exp_cnt, en_cnt, clr_cnt, wait_n;
        bit  ready;
        np      = use_b ? PB : PA;
        npass   = (NOUT + np - 1) / np;
        sel     = use_b;
        x_full  = 1'b1;
        wr_ready = (mode == 0);
        out_drained = 1'b0;
        for (int p = 0; p < npass; p++) begin
            base = p * np;
            tick();
            en_cnt  = 0;
            clr_cnt = 1;
            if (mode == 2) x_full = 1'($urandom_range(0, 1));
            checks++;
            if (o_clr !== 1'b1 || o_en !== 1'b0 || o_wv !== 1'b0 || o_busy !== 1'b1) begin
                failures++;
                $display("FAIL clear p%0d: clr=%b en=%b wv=%b busy=%b, want 1 0 0 1",
                         p, o_clr, o_en, o_wv, o_busy);
            end
            for (int k = 0; k < LENF; k++) begin
                tick();
                if (mode == 2) begin
                    x_full   = 1'($urandom_range(0, 1));
                    wr_ready = 1'($urandom_range(0, 1));
                end
                out_drained = drain_in_mac && (p == 0) && (k == 10);
                en_cnt  += int'(o_en);
                clr_cnt += int'(o_clr);
                checks++;
                if (o_fa !== ADDRF'(k) || o_en !== (k > 0) || o_wv !== 1'b0 ||
                    o_done !== 1'b0 || o_busy !== 1'b1) begin
                    failures++;
                    $display("FAIL mac p%0d k%0d: f_addr=%0d en=%b wv=%b done=%b busy=%b, want %0d %b 0 0 1",
                             p, k, o_fa, o_en, o_wv, o_done, o_busy, k, (k > 0));
                end
                for (int i = 0; i < np; i++) begin
                    exp_a = base + i + k;
                    if (exp_a > LENX - 1) exp_a = LENX - 1;
                    checks++;
                    if (o_xa[i*ADDRX +: ADDRX] !== ADDRX'(exp_a)) begin
                        failures++;
                        $display("FAIL x_addr p%0d k%0d lane%0d: got %0d want %0d",
                                 p, k, i, o_xa[i*ADDRX +: ADDRX], exp_a);
                    end
                end
            end
            tick();
            out_drained = 1'b0;
            en_cnt  += int'(o_en);
            clr_cnt += int'(o_clr);
            checks++;
            if (o_en !== 1'b1 || o_wv !== 1'b0) begin
                failures++;
                $display("FAIL drain p%0d: en=%b wv=%b, want 1 0", p, o_en, o_wv);
            end
            exp_cnt = (NOUT - base < np) ? NOUT - base : np;
            for (int w = 0; w < 64; w++) begin
                tick();
                en_cnt  += int'(o_en);
                clr_cnt += int'(o_clr);
                checks++;
                if (o_wv !== 1'b1 || o_wb !== ADDRX'(base) || o_wc !== 3'(exp_cnt) ||
                    o_lm !== PA'((1 << exp_cnt) - 1)) begin
                    failures++;
                    $display("FAIL write p%0d w%0d: wv=%b base=%0d cnt=%0d mask=%b, want 1 %0d %0d %b",
                             p, w, o_wv, o_wb, o_wc, o_lm, base, exp_cnt,
                             PA'((1 << exp_cnt) - 1));
                end
                case (mode)
                    0:       ready = 1'b1;
                    1:       ready = !(p == 0 && w < 5);
                    default: ready = (w >= 8) || ($urandom_range(0, 2) != 0);
                endcase
                wr_ready = ready;
                if (mode == 2) x_full = 1'($urandom_range(0, 1));
                if (ready) break;
            end
            checks++;
            if (en_cnt != LENF || clr_cnt != 1) begin
                failures++;
                $display("FAIL strobe_count p%0d: en_acc=%0d clr_acc=%0d, want %0d 1",
                         p, en_cnt, clr_cnt, LENF);
            end
        end
        wait_n = (mode == 2) ? int'($urandom_range(0, 6)) : 0;
        for (int d = 0; d <= wait_n; d++) begin
            tick();
            if (mode == 2) x_full = 1'($urandom_range(0, 1));
            checks++;
            if (o_done !== 1'b1 || o_busy !== 1'b1 || o_wv !== 1'b0 || o_xr !== 1'b0 ||
                o_clr !== 1'b0) begin
                failures++;
                $display("FAIL done d%0d: done=%b busy=%b wv=%b xr=%b clr=%b, want 1 1 0 0 0",
                         d, o_done, o_busy, o_wv, o_xr, o_clr);
            end
            out_drained = (d == wait_n);
        end
        tick();
        out_drained = 1'b0;
        x_full = keep_full;
        checks++;
        if (o_xr !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_clr !== 1'b0) begin
            failures++;
            $display("FAIL release: xr=%b busy=%b done=%b clr=%b, want 1 0 0 0",
                     o_xr, o_busy, o_done, o_clr);
        end
        tick();
        checks++;
        if (o_xr !== 1'b0 || o_busy !== 1'b0 || o_clr !== 1'b0) begin
            failures++;
            $display("FAIL post_release: xr=%b busy=%b clr=%b, want 0 0 0", o_xr, o_busy, o_clr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #2;
        checks++;
        if ({xr_a, xa_a, fa_a, clr_a, en_a, wv_a, wb_a, wc_a, lm_a, busy_a, done_a} !== '0) begin
            failures++;
            $display("FAIL reset_a: outputs=%h want 0",
                     {xr_a, xa_a, fa_a, clr_a, en_a, wv_a, wb_a, wc_a, lm_a, busy_a, done_a});
        end
        checks++;
        if ({xr_b, xa_b, fa_b, clr_b, en_b, wv_b, wb_b, wc_b, lm_b, busy_b, done_b} !== '0) begin
            failures++;
            $display("FAIL reset_b: outputs=%h want 0",
                     {xr_b, xa_b, fa_b, clr_b, en_b, wv_b, wb_b, wc_b, lm_b, busy_b, done_b});
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (busy_a !== 1'b0 || clr_a !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b clr=%b, want 0 0", busy_a, clr_a);
        end
    endtask

    task automatic test_default_frame();
        run_frame(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_p3();
        run_frame(1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame(1'b0, 1, 1'b0, 1'b0);
    endtask

    // out_drained pulsed mid-MAC, then x_full left high across x_release.
    task automatic test_back_to_back();
        run_frame(1'b0, 0, 1'b1, 1'b1);
        run_frame(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_mac();
        sel = 1'b0;
        x_full = 1'b1;
        wr_ready = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        checks++;
        if (en_a !== 1'b1 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_mac: en=%b busy=%b, want 1 1", en_a, busy_a);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({xr_a, xa_a, fa_a, clr_a, en_a, wv_a, wb_a, wc_a, lm_a, busy_a, done_a} !== '0) begin
            failures++;
            $display("FAIL async_reset: outputs=%h want 0",
                     {xr_a, xa_a, fa_a, clr_a, en_a, wv_a, wb_a, wc_a, lm_a, busy_a, done_a});
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (wv_a !== 1'b0 || xr_a !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold c%0d: wv=%b xr=%b, want 0 0", c, wv_a, xr_a);
            end
        end
        reset = 1'b0;
        run_frame(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int gap;
        for (int f = 0; f < 4; f++) begin
            gap = int'($urandom_range(0, 4));
            x_full = 1'b0;
            for (int g = 0; g < gap; g++) begin
                tick();
                checks++;
                if (o_busy !== 1'b0 || o_clr !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_gap f%0d: busy=%b clr=%b, want 0 0", f, o_busy, o_clr);
                end
            end
            run_frame(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        sel = 1'b0;
        x_full = 1'b0;
        wr_ready = 1'b0;
        out_drained = 1'b0;
        test_reset();
        test_default_frame();
        test_p3();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mac();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
